// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   // Width of a redirect channel index, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: channel 0 wins; purely combinational, no backpressure.
module pc_redirect_arb
   import pc_gen_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int NUM_REDIRECT = 3,
   parameter int SEL_W        = sel_width(NUM_REDIRECT)
) (
   input  logic [NUM_REDIRECT-1:0]            valid,
   input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] targets,
   output logic                               any_valid,
   output logic [SEL_W-1:0]                   sel,
   output logic [ADDR_WIDTH-1:0]              target
);

   // Scan from the top down so the lowest asserted index is the last writer.
   always_comb begin
      any_valid = 1'b0;
      sel       = '0;
      target    = '0;
      for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
         if (valid[k]) begin
            any_valid = 1'b1;
            sel       = SEL_W'(k);
            target    = targets[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC with prioritised redirects, halt and valid/ready toward IF; redirect-to-PC 1 cycle.
// pc_o is held until accepted unless a redirect withdraws it; PC_GEN_ALIGN_CHECK_EN adds misalign_o.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [31:0] PC_ADDR      = 32'h8000_0000,
   parameter int          ADDR_WIDTH   = 32,
   parameter int          NUM_REDIRECT = 3,
   parameter int          INSTR_BYTES  = 4,
   localparam int         SEL_W        = sel_width(NUM_REDIRECT)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REDIRECT-1:0]            redir_valid_i,
   input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redir_target_i,
   input  logic                               stall_i,
   input  logic                               halt_i,
   output logic [ADDR_WIDTH-1:0]              pc_o,
   output logic                               pc_valid_o,
   input  logic                               pc_ready_i,
   output logic                               flush_o,
   output logic [SEL_W-1:0]                   redir_sel_o,
`ifdef PC_GEN_ALIGN_CHECK_EN
   output logic                               misalign_o,
`endif
   output logic                               halted_o
);

   pc_state_e             state;
   logic                  redir_any;
   logic [SEL_W-1:0]      redir_sel;
   logic [ADDR_WIDTH-1:0] redir_tgt;
   logic [ADDR_WIDTH-1:0] load_tgt;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  xfer;

   pc_redirect_arb #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .NUM_REDIRECT (NUM_REDIRECT),
      .SEL_W        (SEL_W)
   ) u_arb (
      .valid     (redir_valid_i),
      .targets   (redir_target_i),
      .any_valid (redir_any),
      .sel       (redir_sel),
      .target    (redir_tgt)
   );

`ifdef PC_GEN_ALIGN_CHECK_EN
   localparam int ALIGN_BITS = $clog2(INSTR_BYTES);
   logic misaligned;
   assign misaligned = |redir_tgt[ALIGN_BITS-1:0];
   assign load_tgt   = {redir_tgt[ADDR_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};
`else
   assign load_tgt   = redir_tgt;
`endif

   assign xfer   = pc_valid_o && pc_ready_i;
   assign pc_inc = pc_o + ADDR_WIDTH'(INSTR_BYTES);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= BOOT;
         pc_o        <= ADDR_WIDTH'(PC_ADDR);
         pc_valid_o  <= 1'b0;
         flush_o     <= 1'b0;
         redir_sel_o <= '0;
         halted_o    <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
         misalign_o  <= 1'b0;
`endif
      end else begin
         flush_o <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
         misalign_o <= 1'b0;
`endif
         case (state)
            BOOT: begin
               state      <= RUN;
               pc_valid_o <= 1'b1;
            end
            RUN, HALT: begin
               if (redir_any) begin
                  // Redirect withdraws any pending request, even mid-stall or unaccepted.
                  pc_o        <= load_tgt;
                  flush_o     <= 1'b1;
                  redir_sel_o <= redir_sel;
                  pc_valid_o  <= 1'b1;
                  halted_o    <= 1'b0;
                  state       <= RUN;
`ifdef PC_GEN_ALIGN_CHECK_EN
                  misalign_o  <= misaligned;
`endif
               end else if (state == HALT) begin
                  if (!halt_i) begin
                     pc_valid_o <= 1'b1;
                     halted_o   <= 1'b0;
                     state      <= RUN;
                  end
               end else if (halt_i) begin
                  if (xfer) begin
                     pc_o <= pc_inc;
                  end
                  pc_valid_o <= 1'b0;
                  halted_o   <= 1'b1;
                  state      <= HALT;
               end else if (!stall_i && xfer) begin
                  pc_o <= pc_inc;
               end
            end
            default: begin
               state      <= BOOT;
               pc_valid_o <= 1'b0;
               halted_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, backpressure, stall, arbitration, halt, wrap, alignment, async reset.
module tb_pc_gen;

   localparam int AW = 32;
   localparam int NR = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NR-1:0]   redir_valid = '0;
   logic [NR*AW-1:0] redir_target = '0;
   logic            stall = 1'b0;
   logic            halt = 1'b0;
   logic            ready = 1'b1;
   logic [AW-1:0]   pc;
   logic            pc_valid;
   logic            flush;
   logic [1:0]      sel;
   logic            halted;
`ifdef PC_GEN_ALIGN_CHECK_EN
   logic            misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pc_gen #(
      .PC_ADDR      (32'h8000_0000),
      .ADDR_WIDTH   (AW),
      .NUM_REDIRECT (NR),
      .INSTR_BYTES  (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .redir_valid_i  (redir_valid),
      .redir_target_i (redir_target),
      .stall_i        (stall),
      .halt_i         (halt),
      .pc_o           (pc),
      .pc_valid_o     (pc_valid),
      .pc_ready_i     (ready),
      .flush_o        (flush),
      .redir_sel_o    (sel),
`ifdef PC_GEN_ALIGN_CHECK_EN
      .misalign_o     (misalign),
`endif
      .halted_o       (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tgt(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
      redir_target = {t2, t1, t0};
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_valid", {31'b0, pc_valid}, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_sel", {30'b0, sel}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);

      step();
      rst = 1'b0;
      chk("boot_valid", {31'b0, pc_valid}, 32'd0);
      step();
      chk("run0_valid", {31'b0, pc_valid}, 32'd1);
      chk("run0_pc", pc, 32'h8000_0000);
      step();
      chk("run1_pc", pc, 32'h8000_0004);
      step();
      chk("run2_pc", pc, 32'h8000_0008);
      step();
      step();
      chk("run4_pc", pc, 32'h8000_0010);

      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_pc", pc, 32'h8000_0010);
         chk("bp_valid", {31'b0, pc_valid}, 32'd1);
      end
      ready = 1'b1;
      step();
      chk("bp_release_pc", pc, 32'h8000_0014);

      stall = 1'b1;
      step();
      chk("stall_pc", pc, 32'h8000_0014);
      chk("stall_valid", {31'b0, pc_valid}, 32'd1);

      set_tgt(32'h8000_0300, 32'h8000_0100, 32'h8000_0200);
      redir_valid = 3'b110;
      step();
      chk("redir_pc", pc, 32'h8000_0100);
      chk("redir_flush", {31'b0, flush}, 32'd1);
      chk("redir_sel", {30'b0, sel}, 32'd1);
      redir_valid = 3'b111;
      stall = 1'b0;
      step();
      chk("redir_ch0_pc", pc, 32'h8000_0300);
      chk("redir_ch0_flush", {31'b0, flush}, 32'd1);
      chk("redir_ch0_sel", {30'b0, sel}, 32'd0);
      redir_valid = 3'b100;
      step();
      chk("redir_ch2_pc", pc, 32'h8000_0200);
      chk("redir_ch2_flush", {31'b0, flush}, 32'd1);
      chk("redir_ch2_sel", {30'b0, sel}, 32'd2);
      redir_valid = 3'b000;
      step();
      chk("post_redir_flush", {31'b0, flush}, 32'd0);
      chk("post_redir_pc", pc, 32'h8000_0204);

      set_tgt(32'h0, 32'h0, 32'h8000_0020);
      redir_valid = 3'b100;
      step();
      chk("to20_pc", pc, 32'h8000_0020);
      redir_valid = 3'b000;
      halt = 1'b1;
      step();
      chk("halt_halted", {31'b0, halted}, 32'd1);
      chk("halt_valid", {31'b0, pc_valid}, 32'd0);
      chk("halt_pc", pc, 32'h8000_0024);
      chk("halt_flush", {31'b0, flush}, 32'd0);
      step();
      chk("halt_hold_pc", pc, 32'h8000_0024);
      chk("halt_hold_halted", {31'b0, halted}, 32'd1);

      set_tgt(32'h0, 32'h8000_0400, 32'h0);
      redir_valid = 3'b010;
      step();
      chk("halt_redir_halted", {31'b0, halted}, 32'd0);
      chk("halt_redir_valid", {31'b0, pc_valid}, 32'd1);
      chk("halt_redir_pc", pc, 32'h8000_0400);
      chk("halt_redir_flush", {31'b0, flush}, 32'd1);
      redir_valid = 3'b000;
      halt = 1'b0;
      ready = 1'b0;
      step();
      chk("resume_flush", {31'b0, flush}, 32'd0);
      chk("resume_pc", pc, 32'h8000_0400);

      halt = 1'b1;
      step();
      chk("halt_noxfer_halted", {31'b0, halted}, 32'd1);
      chk("halt_noxfer_pc", pc, 32'h8000_0400);
      halt = 1'b0;
      step();
      chk("unhalt_halted", {31'b0, halted}, 32'd0);
      chk("unhalt_valid", {31'b0, pc_valid}, 32'd1);
      chk("unhalt_pc", pc, 32'h8000_0400);

      set_tgt(32'hFFFF_FFFC, 32'h0, 32'h0);
      redir_valid = 3'b001;
      step();
      chk("wrap_tgt_pc", pc, 32'hFFFF_FFFC);
      redir_valid = 3'b000;
      ready = 1'b1;
      step();
      chk("wrap_pc", pc, 32'h0000_0000);

      set_tgt(32'h8000_0102, 32'h0, 32'h0);
      redir_valid = 3'b001;
      step();
`ifdef PC_GEN_ALIGN_CHECK_EN
      chk("align_pc", pc, 32'h8000_0100);
      chk("align_misalign", {31'b0, misalign}, 32'd1);
`else
      chk("align_pc", pc, 32'h8000_0102);
`endif
      chk("align_flush", {31'b0, flush}, 32'd1);
      redir_valid = 3'b000;
      step();
`ifdef PC_GEN_ALIGN_CHECK_EN
      chk("align_misalign_end", {31'b0, misalign}, 32'd0);
`endif

      set_tgt(32'h1234_5670, 32'h0, 32'h0);
      redir_valid = 3'b001;
      #2 rst = 1'b1;
      #1;
      chk("arst_pc", pc, 32'h8000_0000);
      chk("arst_valid", {31'b0, pc_valid}, 32'd0);
      chk("arst_flush", {31'b0, flush}, 32'd0);
      chk("arst_sel", {30'b0, sel}, 32'd0);
      chk("arst_halted", {31'b0, halted}, 32'd0);
      step();
      chk("arst_held_pc", pc, 32'h8000_0000);
      redir_valid = 3'b000;
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation program-counter unit for the fetch stage. It replaces the single-source combinational branch/sequential select with a registered PC.
- Supports N prioritised redirect channels (e.g. exception, mispredict, jump) and a valid/ready handshake toward instruction fetch.
- Provides a halt state and a one-cycle flush pulse on every accepted redirect.
- Sits between the EX/MEM redirect sources and the IF master.

Parameters:
- PC_ADDR, 32'h8000_0000, reset/boot PC.
- ADDR_WIDTH, 32, PC width.
- NUM_REDIRECT, 3, number of redirect channels; channel 0 has highest priority; range 1..8.
- INSTR_BYTES, 4, sequential increment; power of two, at least 2.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- redir_valid_i  in  NUM_REDIRECT  per-channel redirect request.
- redir_target_i  in  NUM_REDIRECT*ADDR_WIDTH  packed targets; channel k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- stall_i  in  1  hold the PC (pipeline hazard).
- halt_i  in  1  enter HALT after the current request.
- pc_o  out  ADDR_WIDTH  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pc_ready_i  in  1  IF accepts pc_o this cycle.
- flush_o  out  1  one-cycle pulse: younger in-flight fetches are dead.
- redir_sel_o  out  $clog2(NUM_REDIRECT) (minimum width 1)  index of the winning channel, valid with flush_o.
- halted_o  out  1  high while in HALT.

Behaviour:
- Reset values: pc_o=PC_ADDR, pc_valid_o=0, flush_o=0, redir_sel_o=0, halted_o=0, state=BOOT.
- States: BOOT, RUN, HALT. All outputs are registered.
- BOOT: one cycle after reset release, unconditionally go to RUN; pc_valid_o=1 from the first RUN cycle.
- RUN:
  - Handshake: a transfer occurs when pc_valid_o && pc_ready_i.
  - Arbitration: the lowest-index asserted redir_valid_i wins.
- RUN priority order (highest first):
  1. Any redirect: next pc_o = winning target; flush_o=1 and redir_sel_o = winner next cycle. This applies regardless of pc_ready_i or stall_i; the pending pc_o is withdrawn (the only legal change of pc_o without a transfer).
  2. halt_i, evaluated only when no redirect is present: if a transfer occurs this cycle, pc_o advances by INSTR_BYTES, then go to HALT. Otherwise go to HALT with pc_o unchanged. The halted PC is the next instruction to fetch.
  3. stall_i: pc_o is held; pc_valid_o stays 1; stall_i does not block the handshake itself.
  4. Transfer: pc_o <= pc_o + INSTR_BYTES, modulo 2^ADDR_WIDTH (wrap-around permitted, no flag).
  5. Otherwise: hold pc_o and pc_valid_o; pc_o stays stable until accepted.
- HALT:
  - pc_valid_o=0, halted_o=1.
  - A redirect loads its target, pulses flush_o, clears halted_o and returns to RUN (pc_valid_o=1 next cycle).
  - Deasserting halt_i alone also returns to RUN with pc_o unchanged.
  - If halt_i and a redirect arrive together, the redirect wins.
- flush_o is exactly one cycle per accepted redirect. Back-to-back redirects give consecutive flush pulses.
- Redirect-to-pc_o latency is 1 cycle; a redirected PC is presented with pc_valid_o=1 on that same cycle.
- rst_i mid-operation: immediate asynchronous return to reset values; any in-progress redirect is discarded.

Optional Feature:
- PC_GEN_ALIGN_CHECK_EN defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - On a winning redirect whose target is not INSTR_BYTES-aligned: misalign_o pulses for 1 cycle alongside flush_o, and pc_o loads the target with its low log2(INSTR_BYTES) bits cleared.
- Undefined: the port is absent and the target is loaded verbatim.

Decomposition:
- pc_gen_pkg:
  - state enum pc_state_e {BOOT, RUN, HALT}.
  - localparam function for the redirect-select width.
- Sub-module pc_redirect_arb: combinational fixed-priority arbiter and target mux. Outputs any_valid, sel index and the selected target. It has its own unit bench.

Test Plan:
- Reset then release, with pc_ready_i=1 held: cycle 1 BOOT with pc_valid_o=0; then pc_o=0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- pc_ready_i=0 for 3 cycles at pc 0x8000_0010 -> pc_o stable, pc_valid_o=1 throughout; advances to 0x8000_0014 the cycle after ready rises.
- Simultaneous redir_valid_i=3'b110 with targets ch1=0x8000_0100 and ch2=0x8000_0200, plus stall_i=1 -> next cycle pc_o=0x8000_0100, flush_o=1, redir_sel_o=1; the cycle after that, flush_o=0.
- halt_i with a transfer at 0x8000_0020 -> halted_o=1, pc_valid_o=0, pc_o=0x8000_0024; a redirect to 0x8000_0400 -> RUN, pc_o=0x8000_0400, flush_o pulse.
- Wrap: redirect to 0xFFFF_FFFC, then accept -> pc_o=0x0000_0000; with the macro, a redirect to 0x8000_0102 gives pc_o=0x8000_0100 and a misalign_o pulse.
- Assert rst_i mid-redirect (redir_valid_i high) -> outputs return to reset values immediately, asynchronously and before the next edge.
